// File: rtl/spi_slave_regbus.sv
// rtl/spi_slave_regbus.sv - SPI mode-0 slave that turns frames into register bus strobes
// Optional feature macro: SPI_SLAVE_ADDR_ECHO_EN (echo received address bits on spi_miso)
// Ports:
//   sys_clk, sys_rst   : system clock, synchronous active-high reset
//   spi_clk, spi_cs_n  : SPI SCLK (mode 0) and active-low chip select, asynchronous
//   spi_mosi, spi_miso : SPI data in / out, MSB first
//   bus_addr           : register address, held between strobes
//   bus_we, bus_wdata  : one-cycle write strobe with its data
//   bus_re, bus_rdata  : one-cycle read strobe; read data sampled 2 cycles later
//   frame_err          : one-cycle pulse when cs_n rises before a frame completes
module spi_slave_regbus #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              spi_clk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-2:0] bus_addr,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_re,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              frame_err
);
   localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int MAX_CNT = (MAX_AD > DUMMY_CYCLES) ? MAX_AD : DUMMY_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [2:0] {IDLE, ADDR, DUMMY, DATA, DONE} state_t;
   state_t state, state_nx;

   // [1:0] is the two-flop synchronizer, [2] the history bit for edge detection
   logic [2:0] sclk_sync;
   logic [2:0] cs_sync;
   logic [1:0] mosi_sync;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;

   logic [ADDR_W-1:0] addr_sr;
   logic [ADDR_W-1:0] addr_full;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] tx_sr;
   logic [CNT_W-1:0]  bit_cnt;
   logic              re_d1;
   logic              abort;
   logic              last_addr, last_dummy, last_data;

   assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
   assign cs_fall    = ~cs_sync[1] & cs_sync[2];
   assign cs_rise    = cs_sync[1] & ~cs_sync[2];
   assign mosi       = mosi_sync[1];
   // address as it will look once the bit on the current rise is shifted in
   assign addr_full  = {addr_sr[ADDR_W-2:0], mosi};
   assign last_addr  = (bit_cnt == CNT_W'(ADDR_W - 1));
   assign last_dummy = (bit_cnt == CNT_W'(DUMMY_CYCLES - 1));
   assign last_data  = (bit_cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      case (state)
         IDLE: if (cs_fall) state_nx = ADDR;
         ADDR: begin
            if (cs_rise) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (sclk_rise && last_addr) begin
               state_nx = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            end
         end
         DUMMY: begin
            if (cs_rise) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (sclk_rise && last_dummy) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (cs_rise) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (sclk_rise && last_data) begin
               state_nx = DONE;
            end
         end
         DONE: if (cs_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         addr_sr   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         bit_cnt   <= '0;
         re_d1     <= 1'b0;
         spi_miso  <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         bus_re    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi_clk};
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         bus_we    <= 1'b0;
         bus_re    <= 1'b0;
         frame_err <= abort;
         re_d1     <= bus_re;

         if (state_nx != state)
            bit_cnt <= '0;
         else if (sclk_rise && (state == ADDR || state == DUMMY || state == DATA))
            bit_cnt <= bit_cnt + CNT_W'(1);

         // bus_rdata is taken on the second edge after the one that raised bus_re
         if (re_d1) tx_sr <= bus_rdata;

         case (state)
            IDLE: begin
               spi_miso <= 1'b0;
               if (cs_fall) begin
                  addr_sr <= '0;
                  rx_sr   <= '0;
                  tx_sr   <= '0;
               end
            end
            ADDR: begin
               if (sclk_rise) begin
                  addr_sr <= addr_full;
                  // only reads that have dummy cycles to hide the bus latency fetch data
                  if (state_nx == DUMMY && addr_full[ADDR_W-1]) begin
                     bus_re   <= 1'b1;
                     bus_addr <= addr_full[ADDR_W-2:0];
                  end
               end
`ifdef SPI_SLAVE_ADDR_ECHO_EN
               if (sclk_fall) spi_miso <= addr_sr[0];
`else
               spi_miso <= 1'b0;
`endif
            end
            DUMMY: begin
`ifdef SPI_SLAVE_ADDR_ECHO_EN
               // the fall closing the last address bit lands here; echo it, then drive 0
               if (sclk_fall) spi_miso <= (bit_cnt == '0) ? addr_sr[0] : 1'b0;
`else
               spi_miso <= 1'b0;
`endif
            end
            DATA: begin
               if (sclk_fall) begin
                  spi_miso <= tx_sr[DATA_W-1];
                  tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
               end
               if (sclk_rise) begin
                  rx_sr <= {rx_sr[DATA_W-2:0], mosi};
                  if (state_nx == DONE && !addr_sr[ADDR_W-1]) begin
                     bus_we    <= 1'b1;
                     bus_addr  <= addr_sr[ADDR_W-2:0];
                     bus_wdata <= {rx_sr[DATA_W-2:0], mosi};
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/spi_slave_regbus.md
SPI_SLAVE_REGBUS -- requirements
Module: spi_slave_regbus

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning SPI address field width; MSB is the read flag, the remaining bits are the register address.
REQ-002 SHALL have parameter DATA_W, default 16, meaning SPI data field and register bus width.
REQ-003 SHALL have parameter DUMMY_CYCLES, default 8, meaning SCLK cycles between the address and data fields.
REQ-004 SHALL have port sys_clk, input, 1, the single clock; all logic is synchronous to it.
REQ-005 SHALL have port sys_rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port spi_clk, input, 1, SPI SCLK (mode 0), asynchronous to sys_clk.
REQ-007 SHALL have port spi_cs_n, input, 1, SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port spi_mosi, input, 1, SPI data in, MSB first.
REQ-009 SHALL have port spi_miso, output, 1, SPI data out, MSB first.
REQ-010 SHALL have port bus_addr, output, ADDR_W-1, register address.
REQ-011 SHALL have port bus_we, output, 1, one-cycle write strobe.
REQ-012 SHALL have port bus_wdata, output, DATA_W, write data, valid with bus_we.
REQ-013 SHALL have port bus_re, output, 1, one-cycle read strobe.
REQ-014 SHALL have port bus_rdata, input, DATA_W, read data, sampled 2 sys_clk after bus_re.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on an aborted frame.

Function
REQ-016 SHALL pass spi_clk, spi_cs_n and spi_mosi through 2-FF synchronizers and derive SCLK rise/fall pulses from the synchronized copies; sys_clk SHALL be at least 4x the SCLK frequency.
REQ-017 SHALL implement states IDLE, ADDR, DUMMY, DATA, DONE; a synchronized cs_n fall moves IDLE->ADDR and clears the bit counter.
REQ-018 SHALL shift spi_mosi into the address register on each SCLK rise in ADDR; after ADDR_W rises, SHALL go to DUMMY.
REQ-019 SHALL assert bus_re for one cycle, with bus_addr set to the address, on the cycle after ADDR->DUMMY when the read flag is 1.
REQ-020 SHALL capture bus_rdata into the transmit shift register exactly 2 cycles after bus_re.
REQ-021 SHALL count DUMMY_CYCLES SCLK rises in DUMMY, then go to DATA; DUMMY_CYCLES=0 SHALL go from ADDR directly to DATA, and the read data SHALL then be 0.
REQ-022 SHALL drive the transmit shift register MSB on spi_miso at the SCLK fall ending the last dummy cycle, then shift one bit per SCLK fall in DATA.
REQ-023 SHALL shift spi_mosi into the receive register on each SCLK rise in DATA; after DATA_W rises, SHALL go to DONE.
REQ-024 In DONE, SHALL pulse bus_we for one cycle with bus_addr/bus_wdata when the read flag is 0; no strobe is issued for reads.
REQ-025 SHALL go from DONE to IDLE on cs_n rise; SCLK edges in DONE SHALL be ignored.
REQ-026 On cs_n rise in ADDR, DUMMY or DATA, SHALL return to IDLE without bus_we and SHALL pulse frame_err.
REQ-027 SHALL hold bus_addr and bus_wdata stable between strobes.
REQ-028 SHALL drive spi_miso to 0 in IDLE and DUMMY, and in ADDR when the configuration feature is out.

Reset
REQ-029 On sys_rst, SHALL reset to state IDLE; spi_miso, bus_we, bus_re and frame_err SHALL be 0; bus_addr, bus_wdata, the shift registers, counters and synchronizers SHALL be 0 (synchronizers for cs_n to 1).
REQ-030 Reset mid-frame SHALL discard the frame; the next cs_n fall SHALL start a fresh frame.

Configuration
REQ-031 With SPI_SLAVE_ADDR_ECHO_EN defined, SHALL drive spi_miso in ADDR with the last received address bit at each SCLK fall, so the master reads back the address; without it, spi_miso SHALL be 0 in ADDR.

Verification
REQ-032 Write addr 0x00 data 0xAAAA, then read 0x80 -> exactly one bus_we with addr 0x00/wdata 0xAAAA; the read returns 0xAAAA with bus_rdata modelled.
REQ-033 Writes of 0x5555, 0x0000, 0x0001, 0x8000, 0xFFFF to addr 0x05 -> bus_wdata matches each value, one bus_we per frame, and bus_re is never asserted.
REQ-034 Read addr 0x83 with bus_rdata=0x2A2A -> one bus_re with bus_addr 0x03; spi_miso shifts 0x2A2A MSB first.
REQ-035 cs_n raised after 10 data bits of a write -> no bus_we; frame_err pulses once; the next full frame completes normally.
REQ-036 sys_rst asserted mid-DATA -> all outputs 0 next cycle; the following write to 0x01 of 0x1234 produces a correct bus_we.
REQ-037 With SPI_SLAVE_ADDR_ECHO_EN defined, send addr 0x85 -> the master captures 0x85 on MISO; without it, the master captures 0x00.
